pkt_reg_v2: RTL

Parametrised packet datapath register for the 1x3 router, the next generation of the byte-wide header/parity register. It sits between the source-side router FSM and the destination FIFOs. It captures the header, forwards header and payload to the FIFO write bus, and buffers bytes that arrive while the FIFO is full in an N-deep skid buffer. It also runs a selectable integrity check, XOR parity or modular checksum, and adds a header-length check.

---
 rtl/router_pkg.sv | 23 ++
 rtl/pkt_skid_buf.sv | 69 ++++++
 rtl/pkt_reg_v2.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router datapath: default widths,
// integrity-check mode encodings and header field helpers.
package router_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_BITS_DEF  = 2;
  localparam int unsigned SKID_DEPTH_DEF = 2;

  localparam int unsigned CHK_XOR = 0;
  localparam int unsigned CHK_SUM = 1;

  // Helpers operate on a 32-bit view so any DATA_WIDTH up to 32 can share them.
  function automatic logic [31:0] hdr_len(input logic [31:0] hdr,
                                          input int unsigned addr_bits);
    return hdr >> addr_bits;
  endfunction

  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr,
                                           input int unsigned addr_bits);
    return hdr & ((32'd1 << addr_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// Circular skid buffer that holds bytes arriving while the destination FIFO
// is full; the head entry is presented combinationally for the next pop.
module pkt_skid_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic                                 pop,
  input  logic [DATA_WIDTH-1:0]                din,
  output logic [DATA_WIDTH-1:0]                head,
  output logic [$clog2(SKID_DEPTH+1)-1:0]      count,
  output logic                                 full,
  output logic                                 empty
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(SKID_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full    = (count == CNT_W'(SKID_DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Pushes happen only in ld_state and pops only in laf_state.
  push_pop_exclusive: assert property (@(posedge clk) disable iff (!rst) !(push && pop));

endmodule

// File: rtl/pkt_reg_v2.sv
// Router packet datapath register: header capture, FIFO write forwarding with
// a skid buffer, selectable XOR/sum integrity check and header-length check.
module pkt_reg_v2
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int unsigned CHK_MODE   = CHK_XOR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pkt_valid,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            fifo_full,
  input  logic                            detect_add,
  input  logic                            lfd_state,
  input  logic                            ld_state,
  input  logic                            laf_state,
  input  logic                            full_state,
  input  logic                            rst_int_reg,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            dout_valid,
  output logic                            parity_done,
  output logic                            low_pkt_valid,
  output logic                            err,
  output logic                            len_err,
  output logic                            ovf_err,
  output logic [$clog2(SKID_DEPTH+1)-1:0] skid_count
);

  localparam int unsigned LEN_W = DATA_WIDTH - ADDR_BITS;

  logic [DATA_WIDTH-1:0] hdr_q;
  logic [LEN_W-1:0]      exp_len;
  logic [DATA_WIDTH-1:0] chk_acc;
  logic [DATA_WIDTH-1:0] chk_next;
  logic [DATA_WIDTH-1:0] pkt_chk;
  logic [DATA_WIDTH-1:0] byte_cnt;

  logic [DATA_WIDTH-1:0] skid_head;
  logic                  skid_full;
  logic                  skid_empty;
  logic                  ld_fwd;
  logic                  ld_push;
  logic                  ld_drop;
  logic                  skid_pop;
  logic                  payload;
  logic                  chk_byte;

  // Once anything is queued, new ld bytes must queue behind it to keep order.
  always_comb begin
    ld_fwd   = ld_state && !fifo_full && skid_empty;
    ld_push  = ld_state && !ld_fwd && !skid_full;
    ld_drop  = ld_state && !ld_fwd && skid_full;
    skid_pop = laf_state && !fifo_full && !skid_empty;
    payload  = ld_state && pkt_valid;
    chk_byte = ld_state && !pkt_valid;
  end

  always_comb begin
    chk_next = chk_acc ^ data_in;
    if (CHK_MODE == CHK_SUM) begin
      chk_next = chk_acc + data_in;
    end
  end

  pkt_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_push),
    .pop   (skid_pop),
    .din   (data_in),
    .head  (skid_head),
    .count (skid_count),
    .full  (skid_full),
    .empty (skid_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q   <= '0;
      exp_len <= '0;
    end else if (pkt_valid && detect_add) begin
      hdr_q   <= data_in;
      exp_len <= LEN_W'(hdr_len(32'(data_in), ADDR_BITS));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (lfd_state) begin
        dout       <= hdr_q;
        dout_valid <= 1'b1;
      end
      if (ld_fwd) begin
        dout       <= data_in;
        dout_valid <= 1'b1;
      end
      if (skid_pop) begin
        dout       <= skid_head;
        dout_valid <= 1'b1;
      end
    end
  end

  // Later assignments deliberately override earlier ones within a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_acc       <= '0;
      pkt_chk       <= '0;
      byte_cnt      <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
      ovf_err       <= 1'b0;
    end else begin
      err <= parity_done && (chk_acc != pkt_chk);
      if (detect_add) begin
        chk_acc     <= '0;
        byte_cnt    <= '0;
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
        ovf_err     <= 1'b0;
      end
      if (lfd_state) begin
        chk_acc <= hdr_q;
      end
      if (ld_drop) begin
        ovf_err <= 1'b1;
      end
      if (payload) begin
        chk_acc  <= chk_next;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (chk_byte) begin
        pkt_chk       <= data_in;
        low_pkt_valid <= 1'b1;
        parity_done   <= 1'b1;
        len_err       <= (byte_cnt != DATA_WIDTH'(exp_len));
      end
      if (rst_int_reg && !pkt_valid) begin
        chk_acc       <= '0;
        low_pkt_valid <= 1'b0;
      end
    end
  end

endmodule
